ring_pe_node_if: RTL and testbench

- Synthesizable PE-side network interface for the bidirectional gold ring; one instance per node, generalised to NUM_NODES nodes.
- Accepts host send requests (destination + payload), buffers them, and computes shortest-path direction and hop field.
- Stamps the VC bit from router polarity and drives the router PE-input handshake.
- Also ejects packets from the router, checks hop field, and hands them to the host with counters and error flags.

---
 rtl/ring_pkg.sv | 36 +++
 rtl/ring_sync_fifo.sv | 80 ++++++++
 rtl/ring_pe_node_if.sv | 161 ++++++++++++++++
 tb/tb_ring_pe_node_if.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - packet field layout and shortest-path route helper for the gold ring
package ring_pkg;

    // Header bit positions, relative to the top 16 bits sitting above the payload
    localparam int HDR_W       = 16;
    localparam int VC_BIT      = 15;
    localparam int DIR_BIT     = 14;
    localparam int RSV_MSB     = 13;
    localparam int RSV_LSB     = 8;
    localparam int HOP_MSB     = 7;
    localparam int HOP_LSB     = 0;
    localparam int RSV_W       = RSV_MSB - RSV_LSB + 1;
    localparam int HOP_FIELD_W = HOP_MSB - HOP_LSB + 1;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    // Returns {dir, thermometer hop}; an exact half-ring tie goes clockwise
    function automatic logic [HOP_FIELD_W:0] ring_route(input int dest, input int id, input int n);
        int d;
        int h;
        logic dir;
        logic [HOP_FIELD_W-1:0] hop;
        d = (dest - id + n) % n;
        if (d <= n / 2) begin
            dir = DIR_CW;
            h   = d;
        end else begin
            dir = DIR_CCW;
            h   = n - d;
        end
        hop = HOP_FIELD_W'((32'd1 << h) - 32'd1);
        return {dir, hop};
    endfunction

endpackage

// File: rtl/ring_sync_fifo.sv
// rtl/ring_sync_fifo.sv - synchronous FIFO with registered full/empty flags
module ring_sync_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("ring_sync_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_wr, do_rd;

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;

    // Next-state for storage, pointers and the occupancy-derived flags
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_wr    = wr_en && !full_q;
        do_rd    = rd_en && !empty_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + CW'(1);
        end else if (!do_wr && do_rd) begin
            count_d = count_q - CW'(1);
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Storage needs no reset; pointers and flags return to empty
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

endmodule

// File: rtl/ring_pe_node_if.sv
// rtl/ring_pe_node_if.sv - PE-side inject/eject interface for one node of the bidirectional ring
module ring_pe_node_if
    import ring_pkg::*;
#(
    parameter int NUM_NODES = 4,
    parameter int NODE_ID   = 0,
    parameter int PAYLOAD_W = 48,
    parameter int HOP_W     = 8,
    parameter int TX_DEPTH  = 4,
    parameter int CNT_W     = 16
)
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         polarity,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [$clog2(NUM_NODES)-1:0] req_dest,
    input  logic [PAYLOAD_W-1:0]         req_payload,
    output logic                         pesi,
    input  logic                         peri,
    output logic [PAYLOAD_W+15:0]        pedi,
    input  logic                         peso,
    output logic                         pero,
    input  logic [PAYLOAD_W+15:0]        pedo,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic [PAYLOAD_W+15:0]        rx_data,
    output logic [CNT_W-1:0]             tx_count,
    output logic [CNT_W-1:0]             rx_count,
    output logic                         err_self,
    output logic                         err_hop
);

    localparam int PW = PAYLOAD_W + HDR_W;

    if (NUM_NODES < 2 || NUM_NODES / 2 > HOP_W || HOP_W > HOP_FIELD_W) begin : g_bad_cfg
        $error("ring_pe_node_if: NUM_NODES/2 must fit in HOP_W, and HOP_W in the 8-bit hop field");
    end

    logic                   fifo_full, fifo_empty;
    logic [PW-1:0]          fifo_head;
    logic [HOP_FIELD_W:0]   route;
    logic [PW-1:0]          req_pkt;
    logic                   take, out_free, req_fire, req_self, req_push;
    logic                   bypass, fifo_rd, fifo_wr, rx_cap;

    logic                   out_valid_q, out_valid_d;
    logic [PW-1:0]          out_data_q, out_data_d;
    logic [CNT_W-1:0]       tx_count_q, tx_count_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [PW-1:0]          rx_data_q, rx_data_d;
    logic [CNT_W-1:0]       rx_count_q, rx_count_d;
    logic                   err_self_q, err_self_d;
    logic                   err_hop_q, err_hop_d;

    assign req_ready = !fifo_full && !reset;
    assign pero      = !reset && (!rx_valid_q || rx_ready);
    assign pesi      = out_valid_q;
    assign pedi      = out_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign tx_count  = tx_count_q;
    assign rx_count  = rx_count_q;
    assign err_self  = err_self_q;
    assign err_hop   = err_hop_q;

    // Build the outgoing packet (VC bit left clear) and steer it: empty queue
    // with a free output register goes straight to the wire, otherwise queue it
    always_comb begin
        route    = ring_route(int'(req_dest), NODE_ID, NUM_NODES);
        req_pkt  = '0;
        req_pkt[PAYLOAD_W+DIR_BIT]                  = route[HOP_FIELD_W];
        req_pkt[PAYLOAD_W+RSV_LSB +: RSV_W]         = '0;
        req_pkt[PAYLOAD_W+HOP_LSB +: HOP_FIELD_W]   = route[HOP_FIELD_W-1:0];
        req_pkt[PAYLOAD_W-1:0]                      = req_payload;
        take     = out_valid_q && peri;
        out_free = !out_valid_q || take;
        req_fire = req_valid && req_ready;
        req_self = req_fire && (int'(req_dest) == NODE_ID);
        req_push = req_fire && !req_self;
        bypass   = req_push && fifo_empty && out_free;
        fifo_rd  = !fifo_empty && out_free;
        fifo_wr  = req_push && !bypass;
    end

    ring_sync_fifo #(
        .WIDTH (PW),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (req_pkt),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Output register, RX register, saturating counters and error flags
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        tx_count_d  = tx_count_q;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        rx_count_d  = rx_count_q;
        err_self_d  = req_self;
        err_hop_d   = err_hop_q;
        rx_cap      = peso && pero;

        if (take && tx_count_q != '1) begin
            tx_count_d = tx_count_q + CNT_W'(1);
        end
        if (fifo_rd || bypass) begin
            out_valid_d = 1'b1;
            out_data_d  = fifo_rd ? fifo_head : req_pkt;
            out_data_d[PAYLOAD_W+VC_BIT] = polarity;
        end else if (take) begin
            out_valid_d = 1'b0;
        end

        if (rx_cap) begin
            rx_valid_d = 1'b1;
            rx_data_d  = pedo;
            if (rx_count_q != '1) begin
                rx_count_d = rx_count_q + CNT_W'(1);
            end
            if (pedo[PAYLOAD_W+HOP_LSB +: HOP_FIELD_W] != '0) begin
                err_hop_d = 1'b1;
            end
        end else if (rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // State update; reset drops any packet in flight in either direction
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            tx_count_q  <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_count_q  <= '0;
            err_self_q  <= 1'b0;
            err_hop_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            tx_count_q  <= tx_count_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            rx_count_q  <= rx_count_d;
            err_self_q  <= err_self_d;
            err_hop_q   <= err_hop_d;
        end
    end

endmodule

// File: tb/tb_ring_pe_node_if.sv
// tb/tb_ring_pe_node_if.sv - self-checking bench for ring_pe_node_if with a queue-based reference model
module tb_ring_pe_node_if;

    localparam int N         = 4;
    localparam int ID        = 0;
    localparam int PAYLOAD_W = 48;
    localparam int HOP_W     = 8;
    localparam int TX_DEPTH  = 4;
    localparam int CNT_W     = 16;
    localparam int PW        = PAYLOAD_W + 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 polarity = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic [1:0]           req_dest = '0;
    logic [PAYLOAD_W-1:0] req_payload = '0;
    logic                 pesi;
    logic                 peri = 1'b0;
    logic [PW-1:0]        pedi;
    logic                 peso = 1'b0;
    logic                 pero;
    logic [PW-1:0]        pedo = '0;
    logic                 rx_valid;
    logic                 rx_ready = 1'b0;
    logic [PW-1:0]        rx_data;
    logic [CNT_W-1:0]     tx_count;
    logic [CNT_W-1:0]     rx_count;
    logic                 err_self;
    logic                 err_hop;

    always #5 clk = ~clk;

    ring_pe_node_if #(
        .NUM_NODES (N),
        .NODE_ID   (ID),
        .PAYLOAD_W (PAYLOAD_W),
        .HOP_W     (HOP_W),
        .TX_DEPTH  (TX_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .polarity    (polarity),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dest    (req_dest),
        .req_payload (req_payload),
        .pesi        (pesi),
        .peri        (peri),
        .pedi        (pedi),
        .peso        (peso),
        .pero        (pero),
        .pedo        (pedo),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .tx_count    (tx_count),
        .rx_count    (rx_count),
        .err_self    (err_self),
        .err_hop     (err_hop)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: shortest way round the ring, hop as a run of d ones
    function automatic logic [63:0] model_pkt(input int dest, input logic [PAYLOAD_W-1:0] pl);
        int d;
        int h;
        logic dir;
        logic [7:0] therm;
        d = ((dest - ID) % N + N) % N;
        if (2 * d <= N) begin
            dir = 1'b0;
            h   = d;
        end else begin
            dir = 1'b1;
            h   = N - d;
        end
        therm = '0;
        for (int i = 0; i < h; i++) therm = {therm[6:0], 1'b1};
        return {1'b0, dir, 6'b0, therm, pl};
    endfunction

    // Everything accepted but not yet taken by the router, oldest first
    logic [63:0] txq[$];
    logic        head_vc = 1'b0;
    int          m_txc = 0;
    int          m_rxc = 0;
    logic        m_rxv = 1'b0;
    logic [63:0] m_rxd = '0;
    logic        m_eself = 1'b0;
    logic        m_ehop = 1'b0;

    always @(negedge clk) begin : model
        logic exp_rr, exp_pero, was_idle, take, fire, self_req;
        exp_rr   = !reset && (txq.size() <= TX_DEPTH);
        exp_pero = !reset && (!m_rxv || rx_ready);

        chk("pesi", 64'(pesi), 64'(txq.size() > 0));
        if (txq.size() > 0) chk("pedi", pedi, {head_vc, txq[0][62:0]});
        chk("req_ready", 64'(req_ready), 64'(exp_rr));
        chk("pero", 64'(pero), 64'(exp_pero));
        chk("rx_valid", 64'(rx_valid), 64'(m_rxv));
        chk("rx_data", rx_data, m_rxd);
        chk("tx_count", 64'(tx_count), 64'(m_txc));
        chk("rx_count", 64'(rx_count), 64'(m_rxc));
        chk("err_self", 64'(err_self), 64'(m_eself));
        chk("err_hop", 64'(err_hop), 64'(m_ehop));

        if (reset) begin
            txq.delete();
            head_vc = 1'b0;
            m_txc   = 0;
            m_rxc   = 0;
            m_rxv   = 1'b0;
            m_rxd   = '0;
            m_eself = 1'b0;
            m_ehop  = 1'b0;
        end else begin
            was_idle = (txq.size() == 0);
            take     = !was_idle && peri;
            if (take) begin
                void'(txq.pop_front());
                if (m_txc < 65535) m_txc++;
            end
            fire     = req_valid && exp_rr;
            self_req = fire && (int'(req_dest) == ID);
            if (fire && !self_req) txq.push_back(model_pkt(int'(req_dest), req_payload));
            if ((was_idle || take) && txq.size() > 0) head_vc = polarity;
            m_eself = self_req;
            if (peso && exp_pero) begin
                m_rxv = 1'b1;
                m_rxd = pedo;
                if (m_rxc < 65535) m_rxc++;
                if (pedo[55:48] != 8'h00) m_ehop = 1'b1;
            end else if (rx_ready) begin
                m_rxv = 1'b0;
            end
        end
    end

    task automatic dsend(input int dest, input logic [PAYLOAD_W-1:0] pl,
                         input logic [63:0] exp_pedi, input int exp_txc);
        tick();
        req_valid   = 1'b1;
        req_dest    = 2'(dest);
        req_payload = pl;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("lit_pesi", 64'(pesi), 64'd1);
        chk("lit_pedi", pedi, exp_pedi);
        tick();
        @(negedge clk);
        chk("lit_tx_count", 64'(tx_count), 64'(exp_txc));
    endtask

    initial begin
        logic [63:0] r;
        logic [63:0] r2;

        reset = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_pedi", pedi, 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_pero", 64'(pero), 64'd0);
        tick();
        reset    = 1'b0;
        peri     = 1'b1;
        polarity = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(req_ready), 64'd1);

        dsend(1, 48'h1,    {1'b1, 1'b0, 6'b0, 8'h01, 48'h1},    1);
        dsend(3, 48'h3,    {1'b1, 1'b1, 6'b0, 8'h01, 48'h3},    2);
        dsend(2, 48'h2222, {1'b1, 1'b0, 6'b0, 8'h03, 48'h2222}, 3);

        // Back-pressure: only five of six requests fit
        tick();
        peri = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid   = 1'b1;
            req_dest    = 2'(1 + (i % 3));
            req_payload = 48'(100 + i);
            polarity    = i[0];
            tick();
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("stall_req_ready", 64'(req_ready), 64'd0);
        chk("stall_tx_count", 64'(tx_count), 64'd3);
        chk("stall_pedi", pedi, {1'b0, 1'b0, 6'b0, 8'h01, 48'd100});
        tick();
        peri = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("drain_tx_count", 64'(tx_count), 64'd8);
        chk("drain_pesi", 64'(pesi), 64'd0);

        // Request addressed to this node is dropped with an error pulse
        tick();
        req_valid = 1'b1;
        req_dest  = 2'(ID);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("self_err", 64'(err_self), 64'd1);
        chk("self_pesi", 64'(pesi), 64'd0);
        tick();
        @(negedge clk);
        chk("self_err_clear", 64'(err_self), 64'd0);
        chk("self_tx_count", 64'(tx_count), 64'd8);

        // Ejection with host back-pressure
        tick();
        rx_ready = 1'b0;
        peso     = 1'b1;
        pedo     = {16'h0, 48'hAAAA};
        tick();
        pedo = {16'h0, 48'hBBBB};
        @(negedge clk);
        chk("rx_hold_valid", 64'(rx_valid), 64'd1);
        chk("rx_hold_pero", 64'(pero), 64'd0);
        tick();
        @(negedge clk);
        chk("rx_hold_data", rx_data, {16'h0, 48'hAAAA});
        tick();
        rx_ready = 1'b1;
        @(negedge clk);
        chk("rx_pass_pero", 64'(pero), 64'd1);
        tick();
        peso = 1'b0;
        @(negedge clk);
        chk("rx_second_data", rx_data, {16'h0, 48'hBBBB});
        chk("rx_count_2", 64'(rx_count), 64'd2);
        chk("rx_no_hop_err", 64'(err_hop), 64'd0);
        tick();
        peso = 1'b1;
        pedo = {8'h00, 8'h01, 48'hC};
        tick();
        peso = 1'b0;
        @(negedge clk);
        chk("hop_err_set", 64'(err_hop), 64'd1);
        chk("rx_count_3", 64'(rx_count), 64'd3);
        tick();
        tick();
        @(negedge clk);
        chk("hop_err_sticky", 64'(err_hop), 64'd1);

        // Random traffic on both directions
        for (int c = 0; c < 3000; c++) begin
            tick();
            req_valid   = ($urandom_range(0, 99) < 60);
            req_dest    = 2'($urandom);
            r           = {$urandom, $urandom};
            req_payload = r[47:0];
            polarity    = 1'($urandom);
            peri        = ($urandom_range(0, 99) < 70);
            peso        = ($urandom_range(0, 99) < 50);
            r2          = {$urandom, $urandom};
            if ($urandom_range(0, 9) != 0) r2[55:48] = 8'h00;
            pedo        = r2;
            rx_ready    = ($urandom_range(0, 99) < 60);
        end

        // Reset with three packets queued and one on the wire
        tick();
        req_valid = 1'b0;
        peso      = 1'b0;
        rx_ready  = 1'b0;
        peri      = 1'b1;
        repeat (10) tick();
        peri = 1'b0;
        peso = 1'b1;
        pedo = {16'h0, 48'h5};
        for (int i = 0; i < 4; i++) begin
            req_valid   = 1'b1;
            req_dest    = 2'd1;
            req_payload = 48'(200 + i);
            tick();
            peso = 1'b0;
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_pesi", 64'(pesi), 64'd1);
        chk("pre_reset_rx_valid", 64'(rx_valid), 64'd1);
        tick();
        reset = 1'b1;
        peri  = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_pesi", 64'(pesi), 64'd0);
        chk("post_reset_rx_valid", 64'(rx_valid), 64'd0);
        chk("post_reset_tx_count", 64'(tx_count), 64'd0);
        chk("post_reset_rx_count", 64'(rx_count), 64'd0);
        chk("post_reset_err_hop", 64'(err_hop), 64'd0);
        repeat (10) tick();
        @(negedge clk);
        chk("post_reset_no_emit", 64'(pesi), 64'd0);
        chk("post_reset_tx_idle", 64'(tx_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
